// File: rtl/vend_ctrl.sv
// Credit-and-dispense sequencer: accepts coins, authorises one vend per purchase,
// then pays change or a refund one coin per cycle.
module vend_ctrl #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 6
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                select,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_code,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_VEND    = 2'b10,
        ST_CHANGE  = 2'b11
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   coin_value = CREDIT_W'(5);
            2'b10:   coin_value = CREDIT_W'(10);
            2'b11:   coin_value = CREDIT_W'(25);
            default: coin_value = '0;
        endcase
    endfunction

    state_t              state_r, state_nxt_s;
    logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
    logic [CREDIT_W-1:0] coin_val_s, eject_s;
    logic [CREDIT_W:0]   sum_s;
    logic                reject_nxt_s, deny_nxt_s;
    logic                dispense_nxt_s, change_valid_nxt_s, busy_nxt_s;
    logic [1:0]          change_code_nxt_s;
    logic                dispense_r, change_valid_r, coin_reject_r, deny_r, busy_r;
    logic [1:0]          change_code_r;

    // Next-state, next-credit and pulse decode; outputs are precomputed from the next state
    always_comb begin
        state_nxt_s  = state_r;
        credit_nxt_s = credit_r;
        reject_nxt_s = 1'b0;
        deny_nxt_s   = 1'b0;
        coin_val_s   = coin_value(coin_code);
        sum_s        = {1'b0, credit_r} + {1'b0, coin_val_s};
        eject_s      = (credit_r >= DIME_C) ? DIME_C : NICKEL_C;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (cancel && (credit_r != '0)) begin
                    state_nxt_s  = ST_CHANGE;
                    reject_nxt_s = coin_valid;
                end else if (select && (credit_r >= PRICE_C)) begin
                    credit_nxt_s = credit_r - PRICE_C;
                    state_nxt_s  = ST_VEND;
                    reject_nxt_s = coin_valid;
                end else begin
                    deny_nxt_s = select;
                    if (coin_valid && (coin_val_s != '0) && (sum_s <= MAX_C)) begin
                        credit_nxt_s = sum_s[CREDIT_W-1:0];
                        state_nxt_s  = ST_COLLECT;
                    end else begin
                        reject_nxt_s = coin_valid;
                    end
                end
            end
            ST_VEND: begin
                reject_nxt_s = coin_valid;
                if (credit_r != '0) begin
                    state_nxt_s = ST_CHANGE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                reject_nxt_s = coin_valid;
                credit_nxt_s = credit_r - eject_s;
                if (credit_r == eject_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHANGE;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                credit_nxt_s = '0;
            end
        endcase
        dispense_nxt_s     = (state_nxt_s == ST_VEND);
        change_valid_nxt_s = (state_nxt_s == ST_CHANGE);
        if (change_valid_nxt_s) begin
            change_code_nxt_s = (credit_nxt_s >= DIME_C) ? 2'b10 : 2'b01;
        end else begin
            change_code_nxt_s = 2'b00;
        end
        busy_nxt_s = dispense_nxt_s | change_valid_nxt_s;
    end

    // State, credit and registered output bank
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_r        <= ST_IDLE;
            credit_r       <= '0;
            dispense_r     <= 1'b0;
            change_valid_r <= 1'b0;
            change_code_r  <= 2'b00;
            coin_reject_r  <= 1'b0;
            deny_r         <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            credit_r       <= credit_nxt_s;
            dispense_r     <= dispense_nxt_s;
            change_valid_r <= change_valid_nxt_s;
            change_code_r  <= change_code_nxt_s;
            coin_reject_r  <= reject_nxt_s;
            deny_r         <= deny_nxt_s;
            busy_r         <= busy_nxt_s;
        end
    end

    assign credit       = credit_r;
    assign dispense     = dispense_r;
    assign change_valid = change_valid_r;
    assign change_code  = change_code_r;
    assign coin_reject  = coin_reject_r;
    assign deny         = deny_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based model of the machine's visible behaviour.
module tb_vend_ctrl;

    localparam int PRICE      = 15;
    localparam int MAX_CREDIT = 40;
    localparam int CREDIT_W   = 6;

    logic                CLK;
    logic                CLR;
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                select;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                change_valid;
    logic [1:0]          change_code;
    logic                coin_reject;
    logic                deny;
    logic                busy;

    vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W)) dut (
        .CLK(CLK), .CLR(CLR), .coin_valid(coin_valid), .coin_code(coin_code),
        .select(select), .cancel(cancel), .credit(credit), .dispense(dispense),
        .change_valid(change_valid), .change_code(change_code),
        .coin_reject(coin_reject), .deny(deny), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One record per busy cycle the machine still owes: vend strobe or one ejected coin.
    typedef struct {
        bit d;
        bit cv;
        int code;
        int cr;
    } rec_t;

    rec_t q[$];
    int   m_credit;
    bit   m_rej, m_deny;
    int   n_pass, n_total;

    function automatic int coin_cents(input logic [1:0] code);
        case (code)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic payout(input int amount);
        int r;
        r = amount;
        while (r > 0) begin
            q.push_back('{d: 1'b0, cv: 1'b1, code: (r >= 10) ? 2 : 1, cr: r});
            r -= (r >= 10) ? 10 : 5;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_credit = 0;
        m_rej    = 1'b0;
        m_deny   = 1'b0;
    endtask

    task automatic model_edge(input bit cvd, input logic [1:0] code, input bit sel, input bit can);
        int v;
        m_rej  = 1'b0;
        m_deny = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_rej = cvd;
        end else if (can && m_credit > 0) begin
            m_rej = cvd;
            payout(m_credit);
            m_credit = 0;
        end else if (sel && m_credit >= PRICE) begin
            m_rej = cvd;
            q.push_back('{d: 1'b1, cv: 1'b0, code: 0, cr: m_credit - PRICE});
            payout(m_credit - PRICE);
            m_credit = 0;
        end else begin
            m_deny = sel;
            if (cvd) begin
                v = coin_cents(code);
                if (v > 0 && m_credit + v <= MAX_CREDIT) m_credit += v;
                else m_rej = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        if (q.size() > 0) begin
            chk("credit", int'(credit), q[0].cr);
            chk("dispense", int'(dispense), int'(q[0].d));
            chk("change_valid", int'(change_valid), int'(q[0].cv));
            chk("change_code", int'(change_code), q[0].code);
            chk("busy", int'(busy), 1);
        end else begin
            chk("credit", int'(credit), m_credit);
            chk("dispense", int'(dispense), 0);
            chk("change_valid", int'(change_valid), 0);
            chk("change_code", int'(change_code), 0);
            chk("busy", int'(busy), 0);
        end
        chk("coin_reject", int'(coin_reject), int'(m_rej));
        chk("deny", int'(deny), int'(m_deny));
    endtask

    task automatic cycle(input bit cvd, input logic [1:0] code, input bit sel, input bit can);
        coin_valid = cvd;
        coin_code  = code;
        select     = sel;
        cancel     = can;
        @(posedge CLK);
        model_edge(cvd, code, sel, can);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Assert CLR between edges and confirm every output drops at once.
    task automatic mid_reset();
        #2 CLR = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("credit_clr", int'(credit), 0);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        CLR = 1'b1;
        coin_valid = 1'b0;
        coin_code = 2'b00;
        select = 1'b0;
        cancel = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;

        // Exact change: dime, nickel, select
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        chk("exact_10", int'(credit), 10);
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        chk("exact_15", int'(credit), 15);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        chk("exact_disp", int'(dispense), 1);
        idle(2);

        // Change payout: quarter, select
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        chk("chg_vend_credit", int'(credit), 10);
        cycle(1'b0, 2'b00, 1'b0, 1'b0);
        chk("chg_code", int'(change_code), 2);
        idle(2);

        // Overflow and slug
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        chk("ovf_reject", int'(coin_reject), 1);
        chk("ovf_credit", int'(credit), 25);
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        chk("slug_reject", int'(coin_reject), 1);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(4);

        // Deny then refund
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        chk("deny_pulse", int'(deny), 1);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        chk("refund_code", int'(change_code), 2);
        idle(2);
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 1'b0, 1'b0);
        chk("refund_nickel", int'(change_code), 1);
        idle(2);

        // Simultaneous events
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b1, 1'b1);
        chk("simul_reject", int'(coin_reject), 1);
        idle(3);
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b1, 1'b0);
        chk("simul_deny_credit", int'(credit), 15);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(3);

        // Reset mid-payout, then a normal vend
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 1'b0, 1'b0);
        mid_reset();
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        idle(3);

        // Held select across a purchase
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                mid_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
